// File: rtl/task_pkg.sv
// Shared definitions for the task dispatchers: task vector sizing and FSM state encoding.
package task_pkg;

    localparam int N_TASK     = 16;
    localparam int TASK_IDX_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_REL  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/task_dispatch_prio_enc16.sv
// Fixed-priority encoder: reports the lowest set request bit (bit 0 wins) and whether any bit is set.
module prio_enc16
    import task_pkg::*;
(
    input  logic [N_TASK-1:0]     req_i,
    output logic                  valid_o,
    output logic [TASK_IDX_W-1:0] idx_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N_TASK - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = TASK_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/task_dispatch.sv
// Responder side of the task req/ack handshake: picks one pending task, runs it on the shared
// worker via start/done, then drops ack to signal completion and waits out the requester latency.
module task_dispatch
    import task_pkg::*;
#(
    parameter int P_TMO_W   = 16,
    parameter int P_HOLDOFF = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_TASK-1:0]     req,
    output logic [N_TASK-1:0]     ack,
    output logic                  task_start,
    output logic [TASK_IDX_W-1:0] task_id,
    input  logic                  task_done,
    input  logic                  task_err,
    output logic                  busy,
    output logic [N_TASK-1:0]     err_flags,
    input  logic [N_TASK-1:0]     err_clr
);

    localparam int HOLD_W = $clog2(P_HOLDOFF + 1);
    // Last RUN cycle before timeout: the count that increments to all-ones.
    localparam logic [P_TMO_W-1:0] WDOG_LAST = ~P_TMO_W'(1);

    state_t                  state_q;
    logic [N_TASK-1:0]       ack_q;
    logic                    task_start_q;
    logic [TASK_IDX_W-1:0]   task_id_q;
    logic                    busy_q;
    logic [N_TASK-1:0]       err_flags_q;
    logic [N_TASK-1:0]       err_flags_d;
    logic [N_TASK-1:0]       err_set;
    logic [P_TMO_W-1:0]      wdog_q;
    logic [HOLD_W-1:0]       hold_q;

    logic                    req_valid;
    logic [TASK_IDX_W-1:0]   req_idx;
    logic                    done_ok;
    logic                    tmo;

    prio_enc16 u_prio (
        .req_i   (req),
        .valid_o (req_valid),
        .idx_o   (req_idx)
    );

    always_comb begin
        // The worker's done is not trusted in the same cycle as its start pulse.
        done_ok     = (state_q == S_RUN) && task_done && !task_start_q;
        tmo         = (state_q == S_RUN) && (wdog_q == WDOG_LAST);
        err_set     = '0;
        if (done_ok ? task_err : tmo) begin
            err_set[task_id_q] = 1'b1;
        end
        err_flags_d = (err_flags_q & ~err_clr) | err_set;
    end

    // NOTE: all state below is sequential, so it is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ack_q        <= '0;
            task_start_q <= 1'b0;
            task_id_q    <= '0;
            busy_q       <= 1'b0;
            err_flags_q  <= '0;
            wdog_q       <= '0;
            hold_q       <= '0;
        end else begin
            err_flags_q  <= err_flags_d;
            task_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        ack_q        <= N_TASK'(1) << req_idx;
                        task_id_q    <= req_idx;
                        task_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        wdog_q       <= '0;
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    wdog_q <= wdog_q + 1'b1;
                    // ack drops as RUN exits, so the REL cycle already shows the falling edge.
                    if (done_ok || tmo) begin
                        ack_q   <= '0;
                        state_q <= S_REL;
                    end
                end
                S_REL: begin
                    ack_q   <= '0;
                    hold_q  <= '0;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_q == HOLD_W'(P_HOLDOFF - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack        = ack_q;
    assign task_start = task_start_q;
    assign task_id    = task_id_q;
    assign busy       = busy_q;
    assign err_flags  = err_flags_q;

endmodule

// File: tb/tb_task_dispatch.sv
// Bench for task_dispatch: timeline model checked every cycle, plus directed scenarios with literal expectations.
module tb_task_dispatch;

    localparam int P_TMO_W   = 4;
    localparam int P_HOLDOFF = 2;
    localparam int TMO_CYC   = (1 << P_TMO_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req_drv = '0;
    logic [15:0] wr_mask = '0;
    logic [15:0] err_clr = '0;
    logic        task_done = 1'b0;
    logic        task_err = 1'b0;
    bit          use_reg = 1'b0;
    bit          chk_en = 1'b0;

    logic [15:0] req;
    logic [15:0] ack;
    logic        task_start;
    logic [3:0]  task_id;
    logic        busy;
    logic [15:0] err_flags;

    // Requester register: bus write sets val bits, a falling ack bit clears it, req lags val by a cycle.
    logic [15:0] val_q;
    logic [15:0] req_reg_q;
    logic [15:0] ack_prev_q;

    int n_tests = 0;
    int n_fail  = 0;

    assign req = use_reg ? req_reg_q : req_drv;

    always #5 clk = ~clk;

    task_dispatch #(
        .P_TMO_W   (P_TMO_W),
        .P_HOLDOFF (P_HOLDOFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .task_start (task_start),
        .task_id    (task_id),
        .task_done  (task_done),
        .task_err   (task_err),
        .busy       (busy),
        .err_flags  (err_flags),
        .err_clr    (err_clr)
    );

    always @(posedge clk) begin
        if (rst) begin
            val_q      <= '0;
            req_reg_q  <= '0;
            ack_prev_q <= '0;
        end else begin
            val_q      <= (val_q | wr_mask) & ~(ack_prev_q & ~ack);
            req_reg_q  <= val_q;
            ack_prev_q <= ack;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Timeline model: a task is described by its start cycle and the cycle its ack goes low.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    bit          m_ending = 1'b0;
    int          m_start = -1;
    int          m_end = -1;
    logic [3:0]  m_id = '0;
    logic [15:0] m_err = '0;
    logic [15:0] m_set;
    int          m_k;

    always @(posedge clk) begin
        cyc++;
        m_set = '0;
        if (rst) begin
            m_busy   = 1'b0;
            m_ending = 1'b0;
            m_id     = '0;
            m_err    = '0;
        end else begin
            if (!m_busy) begin
                if (req != 16'h0) begin
                    m_id     = lowest(req);
                    m_busy   = 1'b1;
                    m_ending = 1'b0;
                    m_start  = cyc;
                end
            end else if (!m_ending) begin
                m_k = cyc - 1 - m_start;
                if (m_k >= 1 && task_done) begin
                    m_ending = 1'b1;
                    m_end    = cyc;
                    if (task_err) m_set[m_id] = 1'b1;
                end else if (m_k == TMO_CYC - 1) begin
                    m_ending = 1'b1;
                    m_end    = cyc;
                    m_set[m_id] = 1'b1;
                end
            end else if (cyc == m_end + 1 + P_HOLDOFF) begin
                m_busy = 1'b0;
            end
            m_err = (m_err & ~err_clr) | m_set;
        end
    end

    // Monitor and per-cycle compare against the model.
    logic [3:0]  started[$];
    int          start_cyc[$];
    int          ack_len = 0;
    logic [15:0] ack_seen = '0;
    logic [15:0] exp_ack;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_ack = (m_busy && !m_ending) ? (16'h1 << m_id) : 16'h0;
            check("ack", ack, exp_ack);
            check("task_start", {15'b0, task_start}, {15'b0, (m_busy && !m_ending && cyc == m_start)});
            check("busy", {15'b0, busy}, {15'b0, m_busy});
            check("err_flags", err_flags, m_err);
            check("ack_onehot0", {15'b0, $onehot0(ack)}, 16'h1);
            if (m_busy) check("task_id", {12'b0, task_id}, {12'b0, m_id});
        end
        if (task_start) begin
            started.push_back(task_id);
            start_cyc.push_back(cyc);
        end
        if (ack != 16'h0) ack_len = (ack_seen == 16'h0) ? 1 : ack_len + 1;
        ack_seen = ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (task_start) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_start: no task_start within 200 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_idle: busy still high after 200 cycles");
    endtask

    // Called at the negedge of the start cycle; done is high in the cycle 'dly' after start.
    task automatic pulse_done(input int dly, input logic err);
        repeat (dly) @(posedge clk);
        #1;
        task_done = 1'b1;
        task_err  = err;
        tick();
        task_done = 1'b0;
        task_err  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 16'h0);
        check("rst_busy", {15'b0, busy}, 16'h0);
        check("rst_start", {15'b0, task_start}, 16'h0);
        check("rst_err", err_flags, 16'h0);
        chk_en = 1'b1;
        rst    = 1'b0;
        tick();

        // Single task, done 5 cycles after start.
        started.delete();
        req_drv = 16'h0004;
        wait_start();
        req_drv = 16'h0;
        check("t1_ack", ack, 16'h0004);
        check("t1_id", {12'b0, task_id}, 16'd2);
        pulse_done(5, 1'b0);
        wait_idle();
        check("t1_ack_len", 16'(ack_len), 16'd6);
        check("t1_starts", 16'(started.size()), 16'd1);
        check("t1_err", err_flags, 16'h0);

        // Three simultaneous requests through the requester register.
        use_reg = 1'b1;
        tick();
        started.delete();
        start_cyc.delete();
        wr_mask = 16'h8011;
        tick();
        wr_mask = 16'h0;
        for (int t = 0; t < 3; t++) begin
            wait_start();
            pulse_done(1, 1'b0);
        end
        wait_idle();
        repeat (3) tick();
        check("t2_starts", 16'(started.size()), 16'd3);
        if (started.size() == 3) begin
            check("t2_order0", {12'b0, started[0]}, 16'd0);
            check("t2_order1", {12'b0, started[1]}, 16'd4);
            check("t2_order2", {12'b0, started[2]}, 16'd15);
            check("t2_gap01", 16'(start_cyc[1] - start_cyc[0]), 16'(4 + P_HOLDOFF));
            check("t2_gap12", 16'(start_cyc[2] - start_cyc[1]), 16'(4 + P_HOLDOFF));
        end
        check("t2_val", val_q, 16'h0);

        // Bus write of two tasks; neither may be served twice.
        started.delete();
        wr_mask = 16'h0003;
        tick();
        wr_mask = 16'h0;
        for (int t = 0; t < 2; t++) begin
            wait_start();
            pulse_done(2, 1'b0);
        end
        wait_idle();
        repeat (10) tick();
        check("t6_starts", 16'(started.size()), 16'd2);
        if (started.size() == 2) begin
            check("t6_order0", {12'b0, started[0]}, 16'd0);
            check("t6_order1", {12'b0, started[1]}, 16'd1);
        end
        check("t6_val", val_q, 16'h0);
        use_reg = 1'b0;
        tick();

        // Timeout; a done in the start cycle must be ignored.
        started.delete();
        req_drv = 16'h0008;
        tick();
        req_drv   = 16'h0;
        task_done = 1'b1;
        wait_start();
        tick();
        task_done = 1'b0;
        wait_idle();
        check("t3_ack_len", 16'(ack_len), 16'(TMO_CYC));
        check("t3_err", err_flags, 16'h0008);
        check("t3_starts", 16'(started.size()), 16'd1);
        tick();
        err_clr = 16'h0008;
        tick();
        err_clr = 16'h0;
        check("t3_clr", err_flags, 16'h0);

        // Done with error on the timeout cycle, err_clr on the same bit in that cycle.
        req_drv = 16'h0002;
        wait_start();
        req_drv = 16'h0;
        repeat (TMO_CYC - 1) @(posedge clk);
        #1;
        task_done = 1'b1;
        task_err  = 1'b1;
        err_clr   = 16'h0002;
        tick();
        task_done = 1'b0;
        task_err  = 1'b0;
        err_clr   = 16'h0;
        wait_idle();
        check("t4_err_set", err_flags, 16'h0002);
        check("t4_ack_len", 16'(ack_len), 16'(TMO_CYC));
        tick();
        err_clr = 16'h0002;
        tick();
        err_clr = 16'h0;
        check("t4_clr", err_flags, 16'h0);

        // Same coincidence without task_err: no flag.
        req_drv = 16'h0002;
        wait_start();
        req_drv = 16'h0;
        pulse_done(TMO_CYC - 1, 1'b0);
        wait_idle();
        check("t4b_err", err_flags, 16'h0);
        check("t4b_ack_len", 16'(ack_len), 16'(TMO_CYC));

        // Reset in the middle of RUN, then a clean restart.
        tick();
        req_drv = 16'h0020;
        wait_start();
        req_drv = 16'h0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t5_ack", ack, 16'h0);
        check("t5_busy", {15'b0, busy}, 16'h0);
        check("t5_start", {15'b0, task_start}, 16'h0);
        rst     = 1'b0;
        req_drv = 16'h0040;
        wait_start();
        req_drv = 16'h0;
        check("t5_id", {12'b0, task_id}, 16'd6);
        check("t5_ack_new", ack, 16'h0040);
        pulse_done(3, 1'b0);
        wait_idle();
        check("t5_err", err_flags, 16'h0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
